// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, I2CSTR bit positions and ACK levels.
// The status bit layout is common to the master and slave blocks.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } slave_state_t;

  localparam int STR_BB     = 12;
  localparam int STR_RSFULL = 11;
  localparam int STR_XSMT   = 10;
  localparam int STR_AAS    = 9;
  localparam int STR_AD0    = 8;
  localparam int STR_SCD    = 5;
  localparam int STR_XRDY   = 4;
  localparam int STR_RRDY   = 3;
  localparam int STR_SDIR   = 2;
  localparam int STR_NACK   = 1;

  localparam logic [15:0] STR_RESET = 16'h0010;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// Host-side register handshake of the I2C slave: own address, TX/RX data,
// status, and the host read/write strobes.
interface i2c_slave_if;
  logic [15:0] I2COAR;
  logic [15:0] I2CDXR;
  logic        din_write;
  logic        dout_read;
  logic [15:0] I2CDRR;
  logic [15:0] I2CSTR;

  modport master (
    output I2COAR, I2CDXR, din_write, dout_read,
    input  I2CDRR, I2CSTR
  );

  modport slave (
    input  I2COAR, I2CDXR, din_write, dout_read,
    output I2CDRR, I2CSTR
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the system clock domain and flags SCL edges
// plus START/STOP conditions as single-cycle pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle bus level so no false edge is seen when reset lifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, write-byte reception into I2CDRR and read-byte
// service from I2CDXR, with an I2CSTR status view. No clock stretching.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  i2c_slave_if.slave  bus,
  inout  wire         i2c_sda,
  input  logic        i2c_scl
);

  logic         scl_rise, scl_fall, start_det, stop_det, sda_s;
  slave_state_t state, state_n;
  logic [3:0]   bit_cnt, bit_cnt_n;
  logic [7:0]   rx_sh, rx_n, tx_sh, tx_n, drr, drr_n;
  logic [7:0]   rx_byte, load_byte;
  logic [15:0]  str_q, str_n;
  logic         sda_low, sda_low_n, rw, rw_n, wrote, wrote_n, do_load;
  logic         unused_bits;

  assign unused_bits = ^{bus.I2COAR[15:7], bus.I2CDXR[15:8]};

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (CLK),
    .rst       (RST),
    .scl       (i2c_scl),
    .sda       (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // The SDA drive flop clears asynchronously, so reset frees the bus at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      drr     <= '0;
      str_q   <= STR_RESET;
      sda_low <= 1'b0;
      rw      <= 1'b0;
      wrote   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      rx_sh   <= rx_n;
      tx_sh   <= tx_n;
      drr     <= drr_n;
      str_q   <= str_n;
      sda_low <= sda_low_n;
      rw      <= rw_n;
      wrote   <= wrote_n;
    end
  end

  assign rx_byte   = {rx_sh[6:0], sda_s};
  assign load_byte = (wrote || bus.din_write) ? bus.I2CDXR[7:0] : 8'hFF;

  // Host strobes are applied first so that bus events in the same cycle win.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_n      = rx_sh;
    tx_n      = tx_sh;
    drr_n     = drr;
    str_n     = str_q;
    sda_low_n = sda_low;
    rw_n      = rw;
    wrote_n   = wrote;
    do_load   = 1'b0;

    if (bus.dout_read) begin
      str_n[STR_RRDY]   = 1'b0;
      str_n[STR_RSFULL] = 1'b0;
    end
    if (bus.din_write) begin
      str_n[STR_XRDY] = 1'b0;
      str_n[STR_XSMT] = 1'b0;
      wrote_n         = 1'b1;
    end

    if (start_det) begin
      state_n         = ST_ADDR;
      bit_cnt_n       = '0;
      sda_low_n       = 1'b0;
      str_n[STR_BB]   = 1'b1;
      str_n[STR_SCD]  = 1'b0;
      str_n[STR_NACK] = 1'b0;
      str_n[STR_AAS]  = 1'b0;
      str_n[STR_AD0]  = 1'b0;
    end else if (stop_det) begin
      state_n        = ST_IDLE;
      sda_low_n      = 1'b0;
      str_n[STR_BB]  = 1'b0;
      str_n[STR_SCD] = 1'b1;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          rx_n      = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rw_n = sda_s;
            if (rx_byte[7:1] == bus.I2COAR[6:0] || rx_byte == 8'h00) begin
              str_n[STR_AAS]  = 1'b1;
              str_n[STR_SDIR] = sda_s;
              if (rx_byte == 8'h00) str_n[STR_AD0] = 1'b1;
              state_n = ST_ADDR_ACK;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end
        // ACK phases: first SCL fall starts driving low, the second ends it.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_low) sda_low_n = 1'b1;
          else if (rw)  do_load   = 1'b1;
          else begin
            sda_low_n = 1'b0;
            bit_cnt_n = '0;
            state_n   = ST_WDATA;
          end
        end
        ST_WDATA: if (scl_rise) begin
          rx_n      = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (!str_q[STR_RRDY]) begin
              drr_n           = rx_byte;
              str_n[STR_RRDY] = 1'b1;
              state_n         = ST_WACK;
            end else begin
              str_n[STR_RSFULL] = 1'b1;
              state_n           = ST_WAIT_STOP;
            end
          end
        end
        ST_WACK: if (scl_fall) begin
          if (!sda_low) sda_low_n = 1'b1;
          else begin
            sda_low_n = 1'b0;
            bit_cnt_n = '0;
            state_n   = ST_WDATA;
          end
        end
        // bit_cnt here counts bits already placed on the bus.
        ST_RDATA: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_low_n = 1'b0;
            state_n   = ST_RACK;
          end else begin
            tx_n      = {tx_sh[6:0], 1'b0};
            sda_low_n = ~tx_sh[6];
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        ST_RACK: begin
          if (scl_rise && bit_cnt == 4'd8) begin
            if (sda_s == I2C_NACK) begin
              str_n[STR_NACK] = 1'b1;
              state_n         = ST_WAIT_STOP;
            end else begin
              bit_cnt_n = 4'd9;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            do_load = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // An empty load (no host write since the last one) sends 0xFF and flags XSMT.
    if (do_load) begin
      tx_n            = load_byte;
      sda_low_n       = ~load_byte[7];
      bit_cnt_n       = 4'd1;
      str_n[STR_XRDY] = 1'b1;
      if (!(wrote || bus.din_write)) str_n[STR_XSMT] = 1'b1;
      wrote_n         = 1'b0;
      state_n         = ST_RDATA;
    end
  end

  assign bus.I2CSTR = str_q;
  assign bus.I2CDRR = {8'h00, drr};
  assign i2c_sda    = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a timed bus master, an address vector
// table, and RX/TX scoreboards fed when stimulus is driven.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int HALF = 5;
  localparam int Q    = 80;

  typedef struct {
    logic [7:0]  addr;
    logic        exp_ack;
    logic [15:0] exp_str_addr;
    logic [15:0] exp_str_stop;
  } addr_vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda_line;

  pullup (sda_line);
  assign sda_line = m_low ? 1'b0 : 1'bz;

  i2c_slave_if ifc ();

  i2c_slave #(.SYNC_STAGES(2)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (ifc),
    .i2c_sda (sda_line),
    .i2c_scl (scl)
  );

  always #HALF CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       rrdy_prev = 1'b0;
  logic       watch_drive = 1'b0;
  logic       slave_drove = 1'b0;
  addr_vec_t  vecs[6];

  function automatic logic sda_bit();
    return (sda_line === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Each newly received byte (RRDY rising) is checked against the RX queue.
  always @(negedge CLK) begin
    if (ifc.I2CSTR[STR_RRDY] && !rrdy_prev) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rx_unexpected actual=%h expected=none", ifc.I2CDRR);
      end else begin
        checkOutput("rx_byte", ifc.I2CDRR, {8'h00, rx_q.pop_front()});
      end
    end
    rrdy_prev = ifc.I2CSTR[STR_RRDY];
    if (watch_drive && !m_low && sda_line === 1'b0) slave_drove = 1'b1;
  end

  initial begin
    #600000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic send_bit(input logic b);
    m_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda_bit();
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) read_bit(b[i]);
    send_bit(ack);
  endtask

  task automatic applyStimulus(input logic din, input logic dout, input logic [15:0] dxr);
    @(posedge CLK);
    #1;
    ifc.I2CDXR    = dxr;
    ifc.din_write = din;
    ifc.dout_read = dout;
    @(posedge CLK);
    #1;
    ifc.din_write = 1'b0;
    ifc.dout_read = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] d);
    tx_q.push_back(d);
    applyStimulus(1'b1, 1'b0, {8'h00, d});
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] rd;

    vecs[0] = '{8'hA0, 1'b0, 16'h1210, 16'h0230};
    vecs[1] = '{8'hA4, 1'b1, 16'h1010, 16'h0030};
    vecs[2] = '{8'h00, 1'b0, 16'h1310, 16'h0330};
    vecs[3] = '{8'h01, 1'b1, 16'h1010, 16'h0030};
    vecs[4] = '{8'hA2, 1'b1, 16'h1010, 16'h0030};
    vecs[5] = '{8'h51, 1'b1, 16'h1010, 16'h0030};

    ifc.I2COAR    = 16'h0050;
    ifc.I2CDXR    = 16'h0000;
    ifc.din_write = 1'b0;
    ifc.dout_read = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("reset_str", ifc.I2CSTR, 16'h0010);
    checkOutput("reset_drr", ifc.I2CDRR, 16'h0000);
    checkOutput("reset_sda", {15'd0, sda_bit()}, 16'h0001);
    RST = 1'b0;
    #(2*Q);

    // Address decode table.
    for (int i = 0; i < 6; i++) begin
      i2c_start();
      write_byte(vecs[i].addr, ack);
      checkOutput($sformatf("addr_ack[%0d]", i), {15'd0, ack}, {15'd0, vecs[i].exp_ack});
      checkOutput($sformatf("addr_str[%0d]", i), ifc.I2CSTR, vecs[i].exp_str_addr);
      i2c_stop();
      checkOutput($sformatf("stop_str[%0d]", i), ifc.I2CSTR, vecs[i].exp_str_stop);
    end

    $display("[TB] write two bytes with host reads");
    i2c_start();
    write_byte(8'hA0, ack);
    checkOutput("w_addr_ack", {15'd0, ack}, 16'h0000);
    rx_q.push_back(8'h3C);
    write_byte(8'h3C, ack);
    checkOutput("w_b1_ack", {15'd0, ack}, 16'h0000);
    applyStimulus(1'b0, 1'b1, ifc.I2CDXR);
    rx_q.push_back(8'h7E);
    write_byte(8'h7E, ack);
    checkOutput("w_b2_ack", {15'd0, ack}, 16'h0000);
    applyStimulus(1'b0, 1'b1, ifc.I2CDXR);
    i2c_stop();
    checkOutput("w_drr", ifc.I2CDRR, 16'h007E);
    checkOutput("w_stop_str", ifc.I2CSTR, 16'h0230);

    $display("[TB] read two bytes, both supplied");
    host_write(8'h5A);
    i2c_start();
    write_byte(8'hA1, ack);
    checkOutput("r_addr_ack", {15'd0, ack}, 16'h0000);
    host_write(8'hC3);
    read_byte(I2C_ACK, rd);
    checkOutput("r_b1", {8'h00, rd}, {8'h00, tx_q.pop_front()});
    read_byte(I2C_NACK, rd);
    checkOutput("r_b2", {8'h00, rd}, {8'h00, tx_q.pop_front()});
    i2c_stop();
    checkOutput("r_stop_str", ifc.I2CSTR, 16'h0236);

    $display("[TB] non-matching address");
    slave_drove = 1'b0;
    watch_drive = 1'b1;
    i2c_start();
    write_byte(8'hA4, ack);
    checkOutput("nm_addr_ack", {15'd0, ack}, 16'h0001);
    write_byte(8'h00, ack);
    checkOutput("nm_data_ack", {15'd0, ack}, 16'h0001);
    checkOutput("nm_str", ifc.I2CSTR, 16'h1014);
    i2c_stop();
    watch_drive = 1'b0;
    checkOutput("nm_no_drive", {15'd0, slave_drove}, 16'h0000);
    checkOutput("nm_stop_str", ifc.I2CSTR, 16'h0034);

    $display("[TB] overrun without host read");
    i2c_start();
    write_byte(8'hA0, ack);
    rx_q.push_back(8'h11);
    write_byte(8'h11, ack);
    checkOutput("ov_b1_ack", {15'd0, ack}, 16'h0000);
    write_byte(8'h22, ack);
    checkOutput("ov_b2_ack", {15'd0, ack}, 16'h0001);
    i2c_stop();
    checkOutput("ov_drr", ifc.I2CDRR, 16'h0011);
    checkOutput("ov_str", ifc.I2CSTR, 16'h0A38);
    applyStimulus(1'b0, 1'b1, ifc.I2CDXR);
    checkOutput("ov_cleared_str", ifc.I2CSTR, 16'h0230);

    $display("[TB] underrun: one host write, two bytes read");
    host_write(8'h96);
    tx_q.push_back(8'hFF);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(I2C_ACK, rd);
    checkOutput("ur_b1", {8'h00, rd}, {8'h00, tx_q.pop_front()});
    read_byte(I2C_NACK, rd);
    checkOutput("ur_b2", {8'h00, rd}, {8'h00, tx_q.pop_front()});
    i2c_stop();
    checkOutput("ur_str", ifc.I2CSTR, 16'h0636);

    $display("[TB] repeated START then reset mid-byte");
    host_write(8'h33);
    i2c_start();
    write_byte(8'hA0, ack);
    rx_q.push_back(8'h55);
    write_byte(8'h55, ack);
    applyStimulus(1'b0, 1'b1, ifc.I2CDXR);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_start();
    write_byte(8'hA1, ack);
    checkOutput("rs_addr_ack", {15'd0, ack}, 16'h0000);
    checkOutput("rs_str", ifc.I2CSTR, 16'h1214);
    read_bit(b);
    checkOutput("rs_bit7", {15'd0, b}, 16'h0000);
    checkOutput("rs_slave_low", {15'd0, sda_bit()}, 16'h0000);
    RST = 1'b1;
    #1;
    checkOutput("rst_sda_release", {15'd0, sda_bit()}, 16'h0001);
    checkOutput("rst_str", ifc.I2CSTR, 16'h0010);
    checkOutput("rst_drr", ifc.I2CDRR, 16'h0000);
    tx_q.delete();
    scl = 1'b1;
    m_low = 1'b0;
    #Q RST = 1'b0;
    #(4*Q);

    checkOutput("rx_q_empty", 16'(rx_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Bus-side target (slave) for the I2C subsystem: the downstream stage that responds to the transfers our master drives on `i2c_sda`/`i2c_scl`. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit own address, receives write bytes into `I2CDRR`, and serves read bytes from `I2CDXR`. Status appears in an `I2CSTR` whose layout mirrors the master's. The block does no clock stretching.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on SCL and SDA (minimum 2).
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-high reset.
- `I2COAR` in 16: own address. Only [6:0] is used.
- `I2CDXR` in 16: transmit data. Only [7:0] is used.
- `din_write` in 1: one-cycle pulse; host has written `I2CDXR`.
- `dout_read` in 1: one-cycle pulse; host has read `I2CDRR`.
- `I2CDRR` out 16: received byte in [7:0]; [15:8] = 0.
- `I2CSTR` out 16: status. [12] BB, [11] RSFULL, [10] XSMT, [9] AAS, [8] AD0, [5] SCD, [4] XRDY, [3] RRDY, [2] SDIR, [1] NACK. All other bits are 0.
- `i2c_sda` inout 1: open-drain. The block drives 0 or Z, never 1.
- `i2c_scl` in 1: bus clock, observed only.

## Operation
**Front end**
- SCL/SDA pass through `SYNC_STAGES` flops, then one edge-detect register.
- START = synchronized SDA falls while SCL is high.
- STOP = synchronized SDA rises while SCL is high.
- SDA samples are taken on SCL rise. The block changes SDA only after SCL fall.

**FSM states:** IDLE, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, WAIT_STOP.
- **START (any state, including repeated START):** go to ADDR; bit count = 0; release SDA; BB=1; clear SCD, NACK, AAS, AD0.
- **STOP (any state):** go to IDLE; release SDA; BB=0; SCD=1.
- **ADDR:** shift in 8 bits, MSB first. After the 8th SCL rise:
  - Match when addr[7:1] == `I2COAR[6:0]`, or when addr[7:1] == 0 with R/W = 0 (general call; also sets AD0).
  - On match, set AAS and SDIR = R/W, and drive SDA low at the next SCL fall; go to ADDR_ACK.
  - No match: go to WAIT_STOP with SDA released.
- **ADDR_ACK:** hold SDA low until the next SCL fall, then:
  - R/W = 1: load the TX shifter from `I2CDXR[7:0]`, drive its bit 7, go to RDATA.
  - R/W = 0: release SDA, go to WDATA.
- **WDATA:** shift in 8 bits. On the 8th SCL rise:
  - RRDY = 0: `I2CDRR[7:0]` ← byte; RRDY = 1; ACK (drive SDA low at the next SCL fall); go to WACK.
  - RRDY = 1 (host has not read the previous byte): byte discarded; RSFULL = 1; NACK (SDA stays released); go to WAIT_STOP.
- **WACK:** release SDA at the next SCL fall; bit count = 0; go to WDATA.
- **RDATA:** drive the next bit at each SCL fall. After the 8th bit's SCL fall, release SDA and go to RACK.
- **RACK:** sample SDA at SCL rise.
  - ACK (0): at the next SCL fall, load the next byte and drive bit 7; go to RDATA.
  - NACK (1): set NACK; go to WAIT_STOP.
- **TX load rule:** every load sets XRDY = 1. If no `din_write` occurred since the previous load, the byte loaded is 0xFF and XSMT = 1.
- **WAIT_STOP:** SDA released; ignore traffic until START or STOP.

**Flags**
- `dout_read` clears RRDY and RSFULL.
- `din_write` clears XRDY and XSMT.

## Timing
- Reset values:
  - FSM = IDLE; SDA released (Z).
  - `I2CDRR` = 0.
  - `I2CSTR` = 0x0010 (XRDY = 1); all other flags 0.
- Latency from a bus edge to internal detection is `SYNC_STAGES` + 1 CLK. The SDA drive change follows within 1 further CLK.
- Required clock ratio: CLK ≥ 16× SCL.
- `I2CSTR` and `I2CDRR` are registered and update 1 CLK after the event.
- Simultaneous events:
  - `dout_read` with a new-byte write: the write wins; RRDY = 1, RSFULL unchanged.
  - `din_write` with a TX load: the load uses that cycle's `I2CDXR`; XRDY = 1; XSMT is not set.
- `RST` mid-transfer: SDA is released immediately (asynchronously). The current transfer is abandoned.

## Structure
- Package `i2c_pkg` holds:
  - The FSM state enum.
  - `I2CSTR` bit index constants (shared with the master).
  - The ACK/NACK constants.
- Sub-module `i2c_bus_sync`: synchronizers plus edge detection. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
- `i2c_slave` holds the FSM, shifters, bit counter and flags.

## Test plan
- `I2COAR` = 0x50; master writes addr 0xA0 then 0x3C, 0x7E; host pulses `dout_read` after each byte → both bytes ACKed; `I2CDRR` = 0x003C then 0x007E; STOP gives SCD = 1, BB = 0.
- Master reads addr 0xA1; `I2CDXR` = 0x5A with `din_write`, then 0xC3; master ACKs byte 1, NACKs byte 2 → bus carries 0x5A, 0xC3; NACK = 1; no XSMT.
- Address 0xA4 (no match) → SDA never driven; AAS = 0; FSM stays in WAIT_STOP until STOP.
- Write of two bytes with no `dout_read` → second byte NACKed; RSFULL = 1; `I2CDRR` keeps the first byte.
- Read of two bytes with only one `din_write` → second byte is 0xFF; XSMT = 1.
- Repeated START mid-write, then read at addr 0xA1 → FSM re-enters ADDR, SDIR = 1; `RST` asserted mid-byte releases SDA immediately and restores the reset status (`I2CSTR` = 0x0010).
